// File: rtl/chiplib_pri_queue_store.sv
// Sorted-register priority queue storage: slot 0 always holds the highest-priority entry.
// Inserts land behind equal priorities, so ties leave the queue in FIFO order.
module chiplib_pri_queue_store #(
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned PriorityWidth = 16,
  parameter int unsigned Depth         = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             queue_push_valid,
  input  logic [DataWidth-1:0]             queue_push_data,
  input  logic [PriorityWidth-1:0]         queue_push_pri,
  output logic                             full,
  output logic                             pop_valid,
  input  logic                             pop_ready,
  output logic [DataWidth-1:0]             pop_data,
  output logic [PriorityWidth-1:0]         pop_pri,
  output logic                             empty,
  output logic [$clog2(Depth+1)-1:0]       count
);

  localparam int unsigned CountWidth = $clog2(Depth + 1);

  typedef struct packed {
    logic                     vld;
    logic [PriorityWidth-1:0] pri;
    logic [DataWidth-1:0]     data;
  } slot_t;

  slot_t                 slot_q  [Depth];
  slot_t                 slot_d  [Depth];
  slot_t                 slot_up [Depth];
  slot_t                 slot_dn [Depth];
  slot_t                 new_slot;
  logic [Depth-1:0]      ge;
  logic [Depth-1:0]      ge_prev;
  logic [Depth-1:0]      ge_next;
  logic [Depth-1:0]      ge_head;
  logic [CountWidth-1:0] count_q;
  logic [CountWidth-1:0] count_d;
  logic                  push;
  logic                  pop;

  // Neighbour views of the slot array and of the per-slot "keeps ahead of new entry" flags
  always_comb begin
    push     = queue_push_valid & ~full;
    pop      = pop_valid & pop_ready;
    new_slot = '{vld: 1'b1, pri: queue_push_pri, data: queue_push_data};
    for (int i = 0; i < Depth; i++) begin
      ge[i] = slot_q[i].vld && (slot_q[i].pri >= queue_push_pri);
    end
    ge_prev = {ge[Depth-2:0], 1'b1};
    ge_next = {1'b0, ge[Depth-1:1]};
    ge_head = {ge[Depth-1:1], 1'b1};
    slot_up[Depth-1] = '0;
    for (int i = 0; i < Depth - 1; i++) begin
      slot_up[i] = slot_q[i+1];
    end
    slot_dn[0] = '0;
    for (int i = 1; i < Depth; i++) begin
      slot_dn[i] = slot_q[i-1];
    end
  end

  // Per-slot next state; ge is a prefix of the valid slots, so the insert point is
  // where ge (or its shifted copy) first drops.
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < Depth; i++) begin
      slot_d[i] = slot_q[i];
      if (push && !pop) begin
        if (ge[i]) begin
          slot_d[i] = slot_q[i];
        end else if (ge_prev[i]) begin
          slot_d[i] = new_slot;
        end else begin
          slot_d[i] = slot_dn[i];
        end
      end else if (push && pop) begin
        if (ge_next[i]) begin
          slot_d[i] = slot_up[i];
        end else if (ge_head[i]) begin
          slot_d[i] = new_slot;
        end else begin
          slot_d[i] = slot_q[i];
        end
      end else if (pop) begin
        slot_d[i] = slot_up[i];
      end
    end
    if (push && !pop) begin
      count_d = count_q + CountWidth'(1);
    end else if (pop && !push) begin
      count_d = count_q - CountWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        slot_q[i] <= '0;
      end
      count_q   <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      pop_valid <= 1'b0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        slot_q[i] <= slot_d[i];
      end
      count_q   <= count_d;
      full      <= (count_d == CountWidth'(Depth));
      empty     <= (count_d == '0);
      pop_valid <= (count_d != '0);
    end
  end

  assign count    = count_q;
  assign pop_data = slot_q[0].data;
  assign pop_pri  = slot_q[0].pri;

  // Upstream must gate push with ~full; the push is dropped if it does not.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(queue_push_valid && full))
        else $error("chiplib_pri_queue_store: push while full");
    end
  end

endmodule

// File: doc/chiplib_pri_queue_store.md
Name: chiplib_pri_queue_store

Overview:
Sorted-register priority queue storage. It sits directly downstream of the push controller and consumes its `queue_push_valid`, `queue_push_data` and `queue_push_pri`. It returns `full` to the push controller and presents the highest-priority entry on a valid/ready pop interface. Entries are kept physically sorted, so slot 0 is always the head.

Parameters:
DataWidth, 64, payload width in bits.
PriorityWidth, 16, priority width in bits. A larger value means higher priority.
Depth, 8, number of entries. Legal range is Depth >= 2.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
queue_push_valid  input  1  insert request; upstream guarantees it is never high while full=1.
queue_push_data  input  DataWidth  payload to insert.
queue_push_pri  input  PriorityWidth  priority of the payload.
full  output  1  count == Depth.
pop_valid  output  1  head entry is valid (count != 0).
pop_ready  input  1  consumer accepts the head.
pop_data  output  DataWidth  payload of slot 0.
pop_pri  output  PriorityWidth  priority of slot 0.
empty  output  1  count == 0.
count  output  $clog2(Depth+1)  number of occupied entries.

Behaviour:
- State:
  - Depth slots, each holding {vld, pri, data}.
  - Slots 0..count-1 are valid and the rest are invalid (valid entries are contiguous from slot 0).
  - Invariant: pri[i] >= pri[i+1] for all valid i.
- Reset:
  - Asynchronous on rst_n low; all vld=0, count=0.
  - Resulting outputs: full=0, empty=1, pop_valid=0.
  - pop_data and pop_pri are 0; data/pri registers reset to 0.
  - Reset mid-operation discards all contents immediately.
- Event qualifiers:
  - pop = pop_valid & pop_ready.
  - push = queue_push_valid.
- Outputs: full, empty, pop_valid and count are derived from registered state only. There is no combinational path from push inputs to any output.
- Push only (no pop):
  - k = number of valid slots with pri >= queue_push_pri.
  - Slots 0..k-1 hold.
  - Slot k takes the new entry.
  - Slots k+1..count shift down by one (slot i takes slot i-1).
  - count increments.
  - Ties resolve FIFO: a new entry goes behind existing entries of equal priority.
- Pop only:
  - Slot i takes slot i+1 for i < Depth-1.
  - Slot Depth-1 becomes invalid.
  - count decrements.
- Push and pop in the same cycle:
  - Slot 0 is removed.
  - k = number of valid slots in 1..count-1 with pri >= queue_push_pri.
  - Resulting slots 0..k-1 take old slots 1..k.
  - Resulting slot k takes the new entry.
  - Resulting slots above k take old slots k+1.. unchanged (no shift).
  - count is unchanged.
  - If the queue was empty, no pop can occur (pop_valid=0).
- Latency:
  - A pushed entry is visible on pop_* the cycle after push.
  - There is no empty-queue bypass.
- Full:
  - A push with full=1 is a protocol violation. The block ignores it (state unchanged apart from any pop) and a simulation assertion fires.
  - Push+pop while full cannot occur, because upstream gates push with ~full.
- Pop interface:
  - pop_data and pop_pri are stable while pop_valid=1 and pop_ready=0, unless a higher-priority push arrives.
  - A higher-priority push replaces the head the next cycle. This is permitted: the head is not a committed transfer until pop_ready.
- Arithmetic:
  - Priority comparison is unsigned and PriorityWidth-bit.
  - Count never wraps; it saturates by construction between 0 and Depth.
- Invalid slots never participate in comparisons; their data is don't-care.

Test Plan:
- Reset, then push pri 5, 9, 1, 9 (data A, B, C, D), then pop with pop_ready=1 each cycle -> pop order B(9), D(9), A(5), C(1); count goes 4,3,2,1,0 and empty=1 at the end.
- Depth=8: push 8 entries with pri 0..7 -> full=1 after the 8th push, count=8. Drive push_valid with full=1 -> assertion fires and contents are unchanged. Pop 8 times -> pri 7 down to 0.
- Queue holds pri {8,6,4}; same cycle push pri 5 and pop -> popped head is 8; next state {6,5,4}, count=3.
- Queue holds pri {8,6,4}; same cycle push pri 10 and pop -> popped 8; next head is pri 10, count=3.
- Empty queue, push pri 3 -> pop_valid=0 in the push cycle and 1 the next cycle with pop_pri=3. Hold pop_ready=0 for 5 cycles -> outputs stable.
- Queue with 3 entries; assert rst_n=0 asynchronously mid-cycle -> empty=1, count=0, pop_valid=0 immediately without waiting for a clock edge. After release, push pri 2 -> behaves from empty.
